// File: rtl/audio_loop_recorder.sv
// audio_loop_recorder: drains the ADC FIFO, records left-channel samples to RAM, plays them back with optional looping
module audio_loop_recorder #(
  parameter int ADDR_W   = 14,
  parameter int SAMPLE_W = 16
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              rec_start,
  input  logic              play_start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic              audio_in_available,
  input  logic [31:0]       left_channel_audio_in,
  output logic              read_audio_in,
  output logic [31:0]       play_sample,
  output logic              recording,
  output logic              playing,
  output logic [ADDR_W:0]   rec_length
);
  typedef enum logic [1:0] {S_IDLE, S_RECORD, S_PLAY} state_t;
  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_wr, r_rd, w_wr_nxt, w_rd_nxt;
  logic [ADDR_W:0]     r_len, w_len_nxt;
  logic                r_read, r_rd_v, r_recording, r_playing;
  logic                w_we, w_re, w_full, w_last, w_unused;
  logic [SAMPLE_W-1:0] r_mem [2**ADDR_W];
  logic [SAMPLE_W-1:0] r_rdata;
  logic [31:0]         r_play;
  assign w_full   = (r_wr == '1);
  assign w_last   = ({1'b0, r_rd} == r_len - 1'b1);
  assign w_unused = ^left_channel_audio_in;
  // Next state: the pending consume event is applied first, then commands override (stop > rec_start > play_start)
  always_comb begin
    w_state_nxt = r_state;
    w_wr_nxt    = r_wr;
    w_rd_nxt    = r_rd;
    w_len_nxt   = r_len;
    w_we        = 1'b0;
    w_re        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (stop) w_state_nxt = S_IDLE;
        else if (rec_start) begin
          w_state_nxt = S_RECORD;
          w_wr_nxt    = '0;
        end else if (play_start && r_len != '0) begin
          w_state_nxt = S_PLAY;
          w_rd_nxt    = '0;
        end
      end
      S_RECORD: begin
        if (r_read) begin
          w_we     = 1'b1;
          w_wr_nxt = r_wr + 1'b1;
          if (w_full) begin
            w_len_nxt   = {1'b1, {ADDR_W{1'b0}}};
            w_state_nxt = S_IDLE;
          end
        end
        if (stop) begin
          w_len_nxt   = {1'b0, r_wr} + {{ADDR_W{1'b0}}, r_read};
          w_state_nxt = S_IDLE;
        end else if (rec_start) begin
          w_wr_nxt    = '0;
          w_state_nxt = S_RECORD;
        end
      end
      S_PLAY: begin
        if (r_read) begin
          w_re     = 1'b1;
          w_rd_nxt = w_last ? '0 : r_rd + 1'b1;
          if (w_last && !loop_en) w_state_nxt = S_IDLE;
        end
        if (stop) w_state_nxt = S_IDLE;
        else if (rec_start) begin
          w_state_nxt = S_RECORD;
          w_wr_nxt    = '0;
        end else if (play_start) begin
          w_state_nxt = S_PLAY;
          w_rd_nxt    = '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end
  // Sample RAM: synchronous write on record consume, one-cycle registered read on play consume
  always_ff @(posedge CLOCK_50) begin
    if (w_we) r_mem[r_wr] <= left_channel_audio_in[31 -: SAMPLE_W];
    if (w_re) r_rdata <= r_mem[r_rd];
  end
  // State, counters, FIFO pop strobe and playback output register
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_wr        <= '0;
      r_rd        <= '0;
      r_len       <= '0;
      r_read      <= 1'b0;
      r_rd_v      <= 1'b0;
      r_play      <= '0;
      r_recording <= 1'b0;
      r_playing   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wr        <= w_wr_nxt;
      r_rd        <= w_rd_nxt;
      r_len       <= w_len_nxt;
      r_read      <= audio_in_available & ~r_read;
      r_rd_v      <= w_re;
      r_play      <= r_rd_v ? 32'(r_rdata) << (32 - SAMPLE_W) : (r_state == S_PLAY ? r_play : '0);
      r_recording <= (w_state_nxt == S_RECORD);
      r_playing   <= (w_state_nxt == S_PLAY);
    end
  end
  assign read_audio_in = r_read;
  assign play_sample   = r_play;
  assign recording     = r_recording;
  assign playing       = r_playing;
  assign rec_length    = r_len;
endmodule

// File: doc/audio_loop_recorder.md
# audio_loop_recorder

Capture-side companion to the audio output path. The block drains the audio controller's ADC input FIFO through the read handshake and records left-channel samples into an on-chip sample RAM. It then plays the recording back, optionally looping, as a 32-bit sample for the mixer. Playback is paced by the same ADC sample cadence, so the recording and playback rates match.

## Interface
Parameters:
- ADDR_W, 14: sample RAM address width. Depth is 2^ADDR_W samples.
- SAMPLE_W, 16: stored width. The upper SAMPLE_W bits of each 32-bit input sample are kept.

Ports:
- CLOCK_50, input, 1: system clock. All logic runs in this single domain.
- resetn, input, 1: reset. Synchronous and active-low.
- rec_start, input, 1: one-cycle pulse that starts recording.
- play_start, input, 1: one-cycle pulse that starts playback.
- stop, input, 1: one-cycle pulse that ends recording or playback.
- loop_en, input, 1: level input. When 1, playback wraps to the start instead of ending.
- audio_in_available, input, 1: audio controller has an ADC sample ready.
- left_channel_audio_in, input, 32: ADC sample. Valid while audio_in_available=1.
- read_audio_in, output, 1: pop strobe to the audio controller.
- play_sample, output, 32: playback sample sent to the mixer.
- recording, output, 1: high while state is RECORD.
- playing, output, 1: high while state is PLAY.
- rec_length, output, ADDR_W+1: number of valid samples in the RAM.

## Operation
- States: IDLE, RECORD, PLAY.
- Draining: the block drains the input FIFO in every state, so the ADC FIFO never backs up.
- Consume event: a cycle in which read_audio_in=1. The sample popped in that cycle is left_channel_audio_in.
- Command priority when several pulses arrive together: stop, then rec_start, then play_start. Commands take effect on the next clock edge.

IDLE:
- rec_start: set wr_addr=0 and go to RECORD.
- play_start with rec_length≠0: set rd_addr=0 and go to PLAY.
- play_start with rec_length=0: ignored.

RECORD:
- Each consume event writes mem[wr_addr] = left_channel_audio_in[31:32-SAMPLE_W], then increments wr_addr.
- stop: set rec_length=wr_addr and go to IDLE. A stop in the same cycle as a consume event still stores that sample, and it is counted in rec_length.
- Full: the consume event that writes address 2^ADDR_W−1 sets rec_length=2^ADDR_W and goes to IDLE.
- rec_start while in RECORD: restarts at wr_addr=0.

PLAY:
- Each consume event reads mem[rd_addr].
- Advance: if rd_addr = rec_length−1, then with loop_en=1 set rd_addr to 0; with loop_en=0 go to IDLE after issuing this last read. Otherwise increment rd_addr.
- stop: go to IDLE.
- rec_start: go to RECORD with wr_addr=0. The old recording is overwritten.
- play_start while in PLAY: restarts at rd_addr=0.

play_sample:
- Holds the most recent RAM read, scaled as {data, (32−SAMPLE_W) zeros}. This preserves the sign of the two's-complement sample.
- Forced to 0 whenever state is not PLAY, once the final pending read has landed.

Arithmetic: the address counters wrap modulo 2^ADDR_W. rec_length holds 0..2^ADDR_W.

## Timing
- Reset (resetn=0 at a clock edge) sets:
  - state=IDLE
  - read_audio_in=0, play_sample=0, recording=0, playing=0
  - rec_length=0, wr_addr=0, rd_addr=0
- RAM contents are not cleared. A reset mid-recording discards the take, because rec_length=0.
- read_audio_in is a registered output. It goes high for exactly one cycle on the edge after a cycle with audio_in_available=1 and read_audio_in=0. As a result there is at most one pop per two cycles, and it is never asserted back-to-back.
- RAM is synchronous, with one cycle of read latency. play_sample updates 2 cycles after the consuming read_audio_in pulse.
- recording and playing are registered and change on the same edge as the state.
- A command pulse arriving in the same cycle as a consume event is applied after that event is processed using the old state's rules.

## Test plan
Benches use ADDR_W=3 (8 samples).
1. Reset and drain:
   - Stimulus: assert resetn=0 for 2 cycles, then hold audio_in_available=1 in IDLE.
   - Response: all outputs are 0 during reset. read_audio_in then toggles 0,1,0,1. State stays IDLE and play_sample stays 0.
2. Record and stop:
   - Stimulus: rec_start, then 5 consume events with samples 0x1111_xxxx through 0x5555_xxxx, then stop.
   - Response: rec_length=5, recording falls on the edge after stop, and RAM[0..4] = 0x1111..0x5555.
3. Play once:
   - Stimulus: after test 2, play_start with loop_en=0.
   - Response: play_sample is 0x11110000, 0x22220000, …, 0x55550000, each appearing 2 cycles after its pop. After the 5th pop, state is IDLE and play_sample returns to 0.
4. Loop:
   - Stimulus: play with loop_en=1 for 12 pops.
   - Response: the output sequence repeats 1,2,3,4,5,1,2,3,4,5,1,2. playing stays 1 throughout.
5. Full and negative samples:
   - Stimulus: record 9 pops of 0x8000_0000 with no stop.
   - Response: auto-return to IDLE after the 8th pop, rec_length=8. Playback gives play_sample=0x80000000.
6. Priority and empty play:
   - Stimulus: after reset, pulse play_start. Then pulse stop, rec_start and play_start in the same cycle while in PLAY.
   - Response: the first play_start is ignored because rec_length=0, so state stays IDLE. The simultaneous pulses resolve to IDLE, since stop wins.
